// File: rtl/mem_rd_arbiter_if.sv
// Handshake bundle between accelerator requesters, the read arbiter and the
// memory control block's ACC read channel.
interface mem_rd_arbiter_if #(
    parameter int C_NUM_REQ          = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512
) ();
    logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_addr;
    logic [C_NUM_REQ-1:0]                    req_valid;
    logic [C_NUM_REQ-1:0]                    req_ready;
    logic [C_M_AXI_DATA_WIDTH-1:0]           rsp_tdata;
    logic [C_NUM_REQ-1:0]                    rsp_tvalid;
    logic [C_NUM_REQ-1:0]                    rsp_tready;
    logic [C_M_AXI_ADDR_WIDTH-1:0]           rd_addr;
    logic                                    rd_valid;
    logic                                    rd_ready;
    logic [C_M_AXI_DATA_WIDTH-1:0]           rd_tdata;
    logic                                    rd_tvalid;
    logic                                    rd_tready;

    // Arbiter view.
    modport slave (
        input  req_addr, req_valid, rsp_tready, rd_ready, rd_tdata, rd_tvalid,
        output req_ready, rsp_tdata, rsp_tvalid, rd_addr, rd_valid, rd_tready
    );

    // Environment view: requesters plus memory control block.
    modport master (
        output req_addr, req_valid, rsp_tready, rd_ready, rd_tdata, rd_tvalid,
        input  req_ready, rsp_tdata, rsp_tvalid, rd_addr, rd_valid, rd_tready
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one read channel among C_NUM_REQ requesters;
// an in-order tag FIFO steers each returned beat back to its requester.
module mem_rd_arbiter #(
    parameter int C_NUM_REQ          = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_MAX_OUTSTANDING  = 16
) (
    input  logic                                aclk,
    input  logic                                areset,
    mem_rd_arbiter_if.slave                     bus,
    output logic [$clog2(C_MAX_OUTSTANDING):0]  outstanding,
    output logic                                err_orphan
);
    localparam int ID_W  = (C_NUM_REQ > 2) ? $clog2(C_NUM_REQ) : 1;
    localparam int PTR_W = $clog2(C_MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int AW    = C_M_AXI_ADDR_WIDTH;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        if (int'(id) == C_NUM_REQ - 1) return '0;
        return id + ID_W'(1);
    endfunction

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             lock_vld_q, lock_vld_d;
    logic [ID_W-1:0]  lock_id_q, lock_id_d;
    logic [ID_W-1:0]  tag_mem [C_MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q;

    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  head;
    logic             full, empty, push, pop, data_ok, found;
    int               idx;

    assign full  = (count_q == CNT_W'(C_MAX_OUTSTANDING));
    assign empty = (count_q == '0);

    // Cyclic search from rr_ptr unless a stalled grant is locked in.
    always_comb begin
        winner = lock_id_q;
        found  = 1'b0;
        idx    = 0;
        if (!lock_vld_q) begin
            winner = rr_ptr_q;
            for (int k = 0; k < C_NUM_REQ; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= C_NUM_REQ) idx = idx - C_NUM_REQ;
                if (!found && bus.req_valid[idx]) begin
                    winner = ID_W'(idx);
                    found  = 1'b1;
                end
            end
        end
    end

    assign bus.rd_valid = (|bus.req_valid) && !full && !areset;
    assign bus.rd_addr  = bus.req_addr[int'(winner)*AW +: AW];
    assign push         = bus.rd_valid && bus.rd_ready;

    always_comb begin
        bus.req_ready = '0;
        if (push) bus.req_ready[winner] = 1'b1;
    end

    assign head          = tag_mem[rd_ptr_q];
    assign data_ok       = !empty && !areset;
    assign bus.rd_tready = data_ok && bus.rsp_tready[head];
    assign bus.rsp_tdata = bus.rd_tdata;
    assign pop           = bus.rd_tvalid && bus.rd_tready;

    always_comb begin
        bus.rsp_tvalid = '0;
        if (bus.rd_tvalid && data_ok) bus.rsp_tvalid[head] = 1'b1;
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        count_d    = count_q;
        if (push) begin
            rr_ptr_d   = next_id(winner);
            lock_vld_d = 1'b0;
        end else if (bus.rd_valid) begin
            lock_vld_d = 1'b1;
            lock_id_d  = winner;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_vld_q <= lock_vld_d;
            count_q    <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (bus.rd_tvalid && empty) err_q <= 1'b1;
        end
    end

    // Tag storage and lock ID are only meaningful behind count/lock_vld.
    always_ff @(posedge aclk) begin
        lock_id_q <= lock_id_d;
        if (push) tag_mem[wr_ptr_q] <= winner;
    end

    assign outstanding = count_q;
    assign err_orphan  = err_q;
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed scenarios plus randomized traffic checked against a queue-based
// model of the arbiter's grant and tag-return rules.
module tb_mem_rd_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MO = 16;

    logic       aclk = 1'b0;
    logic       areset;
    logic [4:0] outstanding;
    logic       err_orphan;

    mem_rd_arbiter_if #(.C_NUM_REQ(N), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) bus ();

    mem_rd_arbiter #(
        .C_NUM_REQ(N), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_MAX_OUTSTANDING(MO)
    ) dut (
        .aclk(aclk), .areset(areset), .bus(bus),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          rr = 0;
    int          lock_id = 0;
    bit          lock_vld = 0;
    bit          err_m = 0;
    int          tagq[$];
    int          win = 0;
    bit          e_rdv = 0;
    bit          e_trdy = 0;
    logic [AW-1:0] addr_a [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pack_addr();
        for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = addr_a[i];
    endtask

    task automatic idle_inputs();
        bus.req_valid  = '0;
        bus.rsp_tready = '0;
        bus.rd_ready   = 1'b0;
        bus.rd_tvalid  = 1'b0;
        bus.rd_tdata   = '0;
        for (int i = 0; i < N; i++) addr_a[i] = '0;
        pack_addr();
    endtask

    function automatic int grant_idx();
        int g = -1;
        for (int k = 0; k < N; k++) if (bus.req_ready[k]) g = k;
        return g;
    endfunction

    // Compare all DUT outputs against the model for the current inputs.
    task automatic eval();
        int n, head;
        logic [N-1:0] e_rsp;
        #1;
        n = tagq.size();
        head = (n > 0) ? tagq[0] : 0;
        if (lock_vld) win = lock_id;
        else begin
            win = rr;
            for (int k = 0; k < N; k++) begin
                if (bus.req_valid[(rr + k) % N]) begin
                    win = (rr + k) % N;
                    break;
                end
            end
        end
        e_rdv  = (bus.req_valid != 0) && (n < MO) && !areset;
        e_trdy = (n > 0) && !areset && bus.rsp_tready[head];
        e_rsp  = (bus.rd_tvalid && n > 0 && !areset) ? N'(1 << head) : '0;
        chk("rd_valid", 64'(bus.rd_valid), 64'(e_rdv));
        if (e_rdv) chk("rd_addr", 64'(bus.rd_addr), 64'(addr_a[win]));
        chk("req_ready", 64'(bus.req_ready), (e_rdv && bus.rd_ready) ? 64'(1) << win : 64'd0);
        chk("rd_tready", 64'(bus.rd_tready), 64'(e_trdy));
        chk("rsp_tvalid", 64'(bus.rsp_tvalid), 64'(e_rsp));
        chk("rsp_tdata", 64'(bus.rsp_tdata), 64'(bus.rd_tdata));
        chk("outstanding", 64'(outstanding), 64'(n));
        chk("err_orphan", 64'(err_orphan), 64'(err_m));
    endtask

    // Apply this cycle's effects to the model, then move to the next cycle.
    task automatic adv();
        if (areset) begin
            tagq.delete();
            rr = 0;
            lock_vld = 0;
            err_m = 0;
        end else begin
            if (bus.rd_tvalid && tagq.size() == 0) err_m = 1;
            if (bus.rd_tvalid && e_trdy) void'(tagq.pop_front());
            if (e_rdv && bus.rd_ready) begin
                tagq.push_back(win);
                rr = (win + 1) % N;
                lock_vld = 0;
            end else if (e_rdv) begin
                lock_vld = 1;
                lock_id = win;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        idle_inputs();
        adv();
        eval();
        adv();
        areset = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        idle_inputs();
        @(posedge aclk);
        #1;
        do_reset();

        // Single read from requester 2
        addr_a[2] = 32'h1000; pack_addr();
        bus.req_valid = 4'b0100; bus.rd_ready = 1'b1;
        eval();
        chk("t1_addr", 64'(bus.rd_addr), 64'h1000);
        chk("t1_req_ready", 64'(bus.req_ready), 64'b0100);
        adv();
        bus.req_valid = '0;
        eval();
        chk("t1_outstanding1", 64'(outstanding), 64'd1);
        adv();
        bus.rd_tvalid = 1'b1; bus.rd_tdata = 64'hAB; bus.rsp_tready = '1;
        eval();
        chk("t1_rsp_tvalid", 64'(bus.rsp_tvalid), 64'b0100);
        chk("t1_rsp_tdata", 64'(bus.rsp_tdata), 64'hAB);
        adv();
        bus.rd_tvalid = 1'b0;
        eval();
        chk("t1_outstanding0", 64'(outstanding), 64'd0);
        adv();

        // Fairness: all valid, 8 grants, then 8 in-order beats
        do_reset();
        for (int i = 0; i < N; i++) addr_a[i] = 32'h100 * (i + 1);
        pack_addr();
        bus.req_valid = '1; bus.rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            eval();
            chk("t2_grant", 64'(grant_idx()), 64'(k % N));
            adv();
        end
        bus.req_valid = '0; bus.rsp_tready = '1; bus.rd_tvalid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.rd_tdata = 64'(k + 16);
            eval();
            chk("t2_rsp_tvalid", 64'(bus.rsp_tvalid), 64'(1) << (k % N));
            adv();
        end
        bus.rd_tvalid = 1'b0;

        // Stall on requester 1 holds address; requester 0 waits its turn
        do_reset();
        addr_a[0] = 32'h1111; addr_a[1] = 32'h2222; pack_addr();
        bus.req_valid = 4'b0010; bus.rd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            eval();
            chk("t3_hold_addr", 64'(bus.rd_addr), 64'h2222);
            adv();
            bus.req_valid = 4'b0011;
        end
        bus.rd_ready = 1'b1;
        eval();
        chk("t3_first", 64'(bus.req_ready), 64'b0010);
        adv();
        bus.req_valid = 4'b0001;
        eval();
        chk("t3_second", 64'(bus.req_ready), 64'b0001);
        adv();

        // Tag FIFO full, then a pop frees one slot
        do_reset();
        addr_a[0] = 32'h4000; pack_addr();
        bus.req_valid = 4'b0001; bus.rd_ready = 1'b1;
        for (int k = 0; k < MO; k++) step();
        eval();
        chk("t4_full_cnt", 64'(outstanding), 64'd16);
        chk("t4_full_rdv", 64'(bus.rd_valid), 64'd0);
        bus.rsp_tready = '1; bus.rd_tvalid = 1'b1;
        eval();
        chk("t4_pop_while_full", 64'(bus.rd_valid), 64'd0);
        adv();
        bus.rd_tvalid = 1'b0;
        eval();
        chk("t4_cnt15", 64'(outstanding), 64'd15);
        chk("t4_17th", 64'(bus.req_ready), 64'b0001);
        adv();
        eval();
        chk("t4_cnt16", 64'(outstanding), 64'd16);

        // Head tag 3 backpressured, then simultaneous accept and pop
        do_reset();
        addr_a[3] = 32'h3000; addr_a[0] = 32'h0F00; pack_addr();
        bus.req_valid = 4'b1000; bus.rd_ready = 1'b1;
        step();
        bus.req_valid = '0; bus.rd_tvalid = 1'b1; bus.rsp_tready = 4'b0111;
        eval();
        chk("t5_tready_low", 64'(bus.rd_tready), 64'd0);
        chk("t5_tvalid_held", 64'(bus.rsp_tvalid), 64'b1000);
        adv();
        bus.rsp_tready = '1; bus.req_valid = 4'b0001;
        eval();
        chk("t5_tready_high", 64'(bus.rd_tready), 64'd1);
        adv();
        bus.req_valid = '0; bus.rd_tvalid = 1'b0;
        eval();
        chk("t5_cnt_same", 64'(outstanding), 64'd1);
        adv();

        // Orphan beat, then reset with 5 outstanding
        do_reset();
        bus.rd_tvalid = 1'b1;
        step();
        bus.rd_tvalid = 1'b0;
        eval();
        chk("t6_orphan", 64'(err_orphan), 64'd1);
        adv();
        bus.req_valid = 4'b0101; bus.rd_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        eval();
        chk("t6_cnt5", 64'(outstanding), 64'd5);
        chk("t6_orphan_sticky", 64'(err_orphan), 64'd1);
        areset = 1'b1; bus.rd_tvalid = 1'b1; bus.rsp_tready = '1;
        eval();
        chk("t6_rst_rdv", 64'(bus.rd_valid), 64'd0);
        chk("t6_rst_rsp", 64'(bus.rsp_tvalid), 64'd0);
        adv();
        areset = 1'b0;
        idle_inputs();
        eval();
        chk("t6_rst_cnt", 64'(outstanding), 64'd0);
        chk("t6_rst_err", 64'(err_orphan), 64'd0);
        adv();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(lock_vld && lock_id == i)) begin
                    bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                    addr_a[i] = $urandom;
                end
            end
            pack_addr();
            bus.rd_ready   = ($urandom_range(0, 3) != 0);
            bus.rsp_tready = N'($urandom);
            bus.rd_tdata   = {$urandom, $urandom};
            if (((c / 300) % 2) == 1)
                bus.rd_tvalid = (tagq.size() > 0) && ($urandom_range(0, 5) == 0);
            else
                bus.rd_tvalid = (tagq.size() > 0) && ($urandom_range(0, 2) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
